bbox_sample_iter: RTL and testbench
===================================

Name: bbox_sample_iter

Overview:
- Sits between the bounding-box stage (R13) and the hash/jitter and sample-test stages (R14 onward).
- Accepts one triangle plus its snapped bounding box at a time and walks every subsample position inside the box in raster order, emitting one sample per cycle.
- Holds off the upstream stage with halt_RnnnnL while a box is being walked.
- Its output triangle/sample/valid stream is what the sample-count and sample-test scoreboards pipe along.

Parameters:
- SIGFIG, 24, bits in every position/color word.
- RADIX, 10, fraction bits in positions (1 pixel = 1<<RADIX).
- VERTS, 3, vertices per triangle.
- AXIS, 3, axes per vertex (x,y,z).
- COLORS, 3, color channels.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- tri_R13S  in  signed [SIGFIG-1:0] [VERTS][AXIS]  triangle vertices.
- color_R13U  in  [SIGFIG-1:0] [COLORS]  triangle color.
- box_R13S  in  signed [SIGFIG-1:0] [2][2]  box; [0]=LL, [1]=UR, [i][0]=x, [i][1]=y.
- validTri_R13H  in  1  triangle/box valid.
- screen_RnnnnS  in  [SIGFIG-1:0] [2]  screen size (static config; pass-through only).
- subSample_RnnnnU  in  [3:0]  one-hot subsample mode, static during a run.
- halt_RnnnnL  out  1  low = upstream must hold its R13 outputs.
- tri_R14S  out  signed [SIGFIG-1:0] [VERTS][AXIS]  latched triangle.
- color_R14U  out  [SIGFIG-1:0] [COLORS]  latched color.
- sample_R14S  out  signed [SIGFIG-1:0] [2]  current sample x,y.
- validSamp_R14H  out  1  sample valid.

Behaviour:
- Subsample step:
  - ss_w_lg2 = 3, 2, 1, 0 for subSample bit 0, 1, 2, 3.
  - step = 1<<(RADIX-ss_w_lg2): 128, 256, 512, 1024.
- Grid alignment: box corners are cleared of bits below step on capture (floor to grid, two's complement).
- State machine, two states:
  - WAIT:
    - halt_RnnnnL=1, validSamp_R14H=0.
    - If validTri_R13H: latch tri, color, aligned box; load sample_R14S=LL; go to TEST.
  - TEST:
    - halt_RnnnnL=0, validSamp_R14H=1.
    - Each cycle advance: if x+step <= URx, then x+=step; else x=LLx and y+=step.
    - Last-sample condition: x+step > URx and y+step > URy. On it, go to WAIT and drive halt_RnnnnL=1 combinationally in that same cycle, so a new triangle can be accepted on the next edge with no bubble.
- Latency: the first sample is valid the cycle after acceptance. Sample count per box = ((URx-LLx)/step+1)*((URy-LLy)/step+1).
- Degenerate box (LL==UR after alignment): exactly one sample, then WAIT.
- Inverted box (URx<LLx or URy<LLy after alignment): zero samples. Stay in WAIT and consume the triangle.
- validTri_R13H while halt_RnnnnL=0 is ignored; upstream is holding.
- Arithmetic: x/y adds use SIGFIG+1 bits to avoid wrap at the positive limit. Output is truncated to SIGFIG.
- Reset (any cycle, including mid-box):
  - state=WAIT, validSamp_R14H=0, halt_RnnnnL=1.
  - tri_R14S, color_R14U, sample_R14S = 0.
  - The partial box is discarded.
- All R14 outputs are registered. Only halt_RnnnnL is combinational from state plus the last-sample condition.

Optional Feature:
- Macro: ITER_STATS_EN. When defined, adds two outputs:
  - samp_cnt_R14U [31:0]: samples emitted for the current triangle. Cleared on acceptance, +1 per valid sample.
  - tri_cnt_R14U [31:0]: triangles accepted since reset. Saturates at 2^32-1.
- Both reset to 0.
- When not defined, neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Mode subSample=4'b1000 (step 1024), box LL(0,0) UR(1024,1024) -> 4 samples (0,0),(1024,0),(0,1024),(1024,1024) on consecutive cycles starting 1 cycle after accept. halt_RnnnnL low 3 cycles, high on the 4th.
- Mode 4'b0100 (step 512), same box -> 9 samples, raster order, last (1024,1024). Next triangle accepted the following cycle with no idle gap.
- Unaligned box LL(300,700) UR(1500,1100), step 1024 -> aligned LL(0,0) UR(1024,1024), 4 samples.
- Degenerate box LL=UR=(2048,2048) -> exactly 1 sample, halt_RnnnnL high in that cycle. Inverted box -> 0 samples, halt_RnnnnL never low.
- Assert rst on the 3rd sample of a 9-sample box -> next cycle validSamp_R14H=0, halt_RnnnnL=1, all outputs 0. A fresh triangle after reset walks from its LL.
- With ITER_STATS_EN, 3 back-to-back boxes of 4, 9, 1 samples -> samp_cnt_R14U ends at 4, 9, 1 respectively; tri_cnt_R14U=3.

Source files
------------

// File: rtl/bbox_sample_iter.sv
// Walks every subsample grid point of a snapped bounding box in raster order, one per cycle.
// Define ITER_STATS_EN to add the samp_cnt_R14U / tri_cnt_R14U statistics outputs.
module bbox_sample_iter #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R13S [2][2],
  input  logic                     validTri_R13H,
  input  logic        [SIGFIG-1:0] screen_RnnnnS [2],
  input  logic        [3:0]        subSample_RnnnnU,
  output logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R14U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R14S [2],
  output logic                     validSamp_R14H
`ifdef ITER_STATS_EN
  ,
  output logic        [31:0]       samp_cnt_R14U,
  output logic        [31:0]       tri_cnt_R14U
`endif
);

  localparam int EXT = SIGFIG + 1;
  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_TEST = 1'b1;
  localparam logic signed [EXT-1:0] UNIT    = {{(EXT-1){1'b0}}, 1'b1};
  localparam logic signed [EXT-1:0] ONE_PIX = {{(EXT-RADIX-1){1'b0}}, 1'b1, {RADIX{1'b0}}};

  function automatic logic signed [EXT-1:0] sext(input logic signed [SIGFIG-1:0] v);
    return {v[SIGFIG-1], v};
  endfunction

  logic [0:0]              state_q, state_d;
  logic signed [SIGFIG-1:0] tri_q [VERTS][AXIS];
  logic signed [SIGFIG-1:0] tri_d [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_q [COLORS];
  logic        [SIGFIG-1:0] color_d [COLORS];
  logic signed [EXT-1:0]   x_q, x_d, y_q, y_d;
  logic signed [EXT-1:0]   llx_q, llx_d, urx_q, urx_d, ury_q, ury_d;

  logic [1:0]              ss_w_lg2_s;
  logic signed [EXT-1:0]   step_s, mask_s;
  logic signed [EXT-1:0]   llx_a_s, lly_a_s, urx_a_s, ury_a_s;
  logic signed [EXT-1:0]   next_x_s, next_y_s;
  logic                    inverted_s, last_s, halt_s, accept_s;
  logic                    unused_screen_s;

`ifdef ITER_STATS_EN
  logic [31:0] samp_cnt_q, samp_cnt_d, tri_cnt_q, tri_cnt_d;
`endif

  // Screen size is carried for downstream stages but not consumed here.
  assign unused_screen_s = ^{screen_RnnnnS[0], screen_RnnnnS[1]};

  always_comb begin
    case (subSample_RnnnnU)
      4'b0001: ss_w_lg2_s = 2'd3;
      4'b0010: ss_w_lg2_s = 2'd2;
      4'b0100: ss_w_lg2_s = 2'd1;
      4'b1000: ss_w_lg2_s = 2'd0;
      default: ss_w_lg2_s = 2'd0;
    endcase
    step_s = ONE_PIX >> ss_w_lg2_s;
    mask_s = ~(step_s - UNIT);
  end

  // Masking low bits of a two's-complement value floors it toward -inf onto the grid.
  always_comb begin
    llx_a_s    = sext(box_R13S[0][0]) & mask_s;
    lly_a_s    = sext(box_R13S[0][1]) & mask_s;
    urx_a_s    = sext(box_R13S[1][0]) & mask_s;
    ury_a_s    = sext(box_R13S[1][1]) & mask_s;
    inverted_s = (urx_a_s < llx_a_s) || (ury_a_s < lly_a_s);
    next_x_s   = x_q + step_s;
    next_y_s   = y_q + step_s;
    last_s     = (next_x_s > urx_q) && (next_y_s > ury_q);
    halt_s     = (state_q == ST_WAIT) ? 1'b1 : last_s;
    accept_s   = validTri_R13H && halt_s;
  end

  always_comb begin
    state_d = state_q;
    tri_d   = tri_q;
    color_d = color_q;
    x_d     = x_q;
    y_d     = y_q;
    llx_d   = llx_q;
    urx_d   = urx_q;
    ury_d   = ury_q;
`ifdef ITER_STATS_EN
    samp_cnt_d = samp_cnt_q;
    tri_cnt_d  = tri_cnt_q;
`endif
    if (accept_s) begin
      tri_d   = tri_R13S;
      color_d = color_R13U;
`ifdef ITER_STATS_EN
      tri_cnt_d = (tri_cnt_q != 32'hFFFF_FFFF) ? tri_cnt_q + 32'd1 : tri_cnt_q;
`endif
      if (inverted_s) begin
        state_d = ST_WAIT;
`ifdef ITER_STATS_EN
        samp_cnt_d = 32'd0;
`endif
      end else begin
        state_d = ST_TEST;
        x_d     = llx_a_s;
        y_d     = lly_a_s;
        llx_d   = llx_a_s;
        urx_d   = urx_a_s;
        ury_d   = ury_a_s;
`ifdef ITER_STATS_EN
        samp_cnt_d = 32'd1;
`endif
      end
    end else if (state_q == ST_TEST) begin
      if (last_s) begin
        state_d = ST_WAIT;
      end else begin
`ifdef ITER_STATS_EN
        samp_cnt_d = samp_cnt_q + 32'd1;
`endif
        if (next_x_s <= urx_q) begin
          x_d = next_x_s;
        end else begin
          x_d = llx_q;
          y_d = next_y_s;
        end
      end
    end else begin
      state_d = ST_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT;
      for (int v = 0; v < VERTS; v++) begin
        for (int a = 0; a < AXIS; a++) begin
          tri_q[v][a] <= {SIGFIG{1'b0}};
        end
      end
      for (int c = 0; c < COLORS; c++) begin
        color_q[c] <= {SIGFIG{1'b0}};
      end
      x_q   <= {EXT{1'b0}};
      y_q   <= {EXT{1'b0}};
      llx_q <= {EXT{1'b0}};
      urx_q <= {EXT{1'b0}};
      ury_q <= {EXT{1'b0}};
`ifdef ITER_STATS_EN
      samp_cnt_q <= 32'd0;
      tri_cnt_q  <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      color_q <= color_d;
      x_q     <= x_d;
      y_q     <= y_d;
      llx_q   <= llx_d;
      urx_q   <= urx_d;
      ury_q   <= ury_d;
`ifdef ITER_STATS_EN
      samp_cnt_q <= samp_cnt_d;
      tri_cnt_q  <= tri_cnt_d;
`endif
    end
  end

  assign halt_RnnnnL    = halt_s;
  assign tri_R14S       = tri_q;
  assign color_R14U     = color_q;
  assign sample_R14S[0] = x_q[SIGFIG-1:0];
  assign sample_R14S[1] = y_q[SIGFIG-1:0];
  assign validSamp_R14H = (state_q == ST_TEST);
`ifdef ITER_STATS_EN
  assign samp_cnt_R14U = samp_cnt_q;
  assign tri_cnt_R14U  = tri_cnt_q;
`endif

endmodule

// File: tb/tb_bbox_sample_iter.sv
// Randomized scoreboard bench for bbox_sample_iter; the reference model enumerates grid points
// of each floored box with plain integer arithmetic and schedules them by cycle.
module tb_bbox_sample_iter;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [23:0]       tri_in [3][3];
  logic        [23:0]       color_in [3];
  logic signed [23:0]       box_in [2][2];
  logic                     valid_tri;
  logic        [23:0]       screen [2];
  logic        [3:0]        sub_sample;
  logic                     halt;
  logic signed [23:0]       tri_out [3][3];
  logic        [23:0]       color_out [3];
  logic signed [23:0]       sample [2];
  logic                     valid_samp;
`ifdef ITER_STATS_EN
  logic        [31:0]       samp_cnt;
  logic        [31:0]       tri_cnt;
`endif

  bbox_sample_iter dut (
    .clk(clk), .rst(rst), .tri_R13S(tri_in), .color_R13U(color_in), .box_R13S(box_in),
    .validTri_R13H(valid_tri), .screen_RnnnnS(screen), .subSample_RnnnnU(sub_sample),
    .halt_RnnnnL(halt), .tri_R14S(tri_out), .color_R14U(color_out),
    .sample_R14S(sample), .validSamp_R14H(valid_samp)
`ifdef ITER_STATS_EN
    , .samp_cnt_R14U(samp_cnt), .tri_cnt_R14U(tri_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int y; int cyc; int id; bit last; int idx; int tcnt;
  } exp_t;

  exp_t sb[$];
  int   tri_mem [0:511][0:8];
  int   col_mem [0:511][0:2];
  int   cyc = 0, seen = 0, next_id = 0, tcnt_m = 0;
  int   pass_cnt = 0, total_cnt = 0;
  bit   mon_en = 1'b0;
  exp_t e;

  task automatic chk(input string nm, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int floor_to(input int v, input int s);
    int q = v / s;
    if ((v % s != 0) && (v < 0)) q = q - 1;
    return q * s;
  endfunction

  function automatic int step_of(input logic [3:0] m);
    case (m)
      4'b0001: return 128;
      4'b0010: return 256;
      4'b0100: return 512;
      default: return 1024;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a sample must appear exactly in the cycle the model scheduled it.
  always @(negedge clk) begin
    if (mon_en) begin
      bit due;
      due = (sb.size() > 0) && (sb[0].cyc <= cyc);
      chk("valid", valid_samp, due);
      if (valid_samp && sb.size() > 0) begin
        int mism = 0;
        e = sb.pop_front();
        seen++;
        chk("sample_x", sample[0], e.x);
        chk("sample_y", sample[1], e.y);
        for (int v = 0; v < 3; v++)
          for (int a = 0; a < 3; a++)
            if (int'(tri_out[v][a]) != tri_mem[e.id][v*3+a]) mism++;
        for (int c = 0; c < 3; c++)
          if (int'(color_out[c]) != col_mem[e.id][c]) mism++;
        chk("tri_color_mismatches", mism, 0);
        chk("halt_busy", halt, e.last);
`ifdef ITER_STATS_EN
        chk("samp_cnt", samp_cnt, e.idx + 1);
        chk("tri_cnt", tri_cnt, e.tcnt);
`endif
      end else begin
        chk("halt_idle", halt, 1);
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic send(input int llx, input int lly, input int urx, input int ury);
    int w = 0;
    int s, ax0, ay0, ax1, ay1, id, n, k;
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++) begin
        int r = int'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
        tri_in[v][a] = r[23:0];
        tri_mem[next_id % 512][v*3+a] = r;
      end
    for (int c = 0; c < 3; c++) begin
      int r = int'($urandom_range(0, 32'h00FF_FFFF));
      color_in[c] = r[23:0];
      col_mem[next_id % 512][c] = r;
    end
    box_in[0][0] = llx[23:0]; box_in[0][1] = lly[23:0];
    box_in[1][0] = urx[23:0]; box_in[1][1] = ury[23:0];
    valid_tri = 1'b1;
    while (!halt && w < 300) begin tick(); w++; end
    if (!halt) begin
      chk("accept_wait", halt, 1);
      valid_tri = 1'b0;
      return;
    end
    s   = step_of(sub_sample);
    ax0 = floor_to(llx, s); ay0 = floor_to(lly, s);
    ax1 = floor_to(urx, s); ay1 = floor_to(ury, s);
    id  = next_id % 512;
    next_id++;
    tcnt_m++;
    if (ax1 >= ax0 && ay1 >= ay0) begin
      n = ((ax1 - ax0) / s + 1) * ((ay1 - ay0) / s + 1);
      k = 0;
      for (int y = ay0; y <= ay1; y += s)
        for (int x = ax0; x <= ax1; x += s) begin
          sb.push_back('{x: x, y: y, cyc: cyc + 1 + k, id: id, last: (k == n - 1),
                         idx: k, tcnt: tcnt_m});
          k++;
        end
    end
    tick();
    valid_tri = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    valid_tri = 1'b0;
    while ((sb.size() > 0 || !halt) && w < 500) begin tick(); w++; end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic check_reset_state(input string nm);
    int nz = 0;
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++) if (tri_out[v][a] != 24'sd0) nz++;
    for (int c = 0; c < 3; c++) if (color_out[c] != 24'd0) nz++;
    if (sample[0] != 24'sd0 || sample[1] != 24'sd0) nz++;
    chk({nm, "_valid"}, valid_samp, 0);
    chk({nm, "_halt"}, halt, 1);
    chk({nm, "_nonzero_outputs"}, nz, 0);
`ifdef ITER_STATS_EN
    chk({nm, "_samp_cnt"}, samp_cnt, 0);
    chk({nm, "_tri_cnt"}, tri_cnt, 0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_tri = 1'b0;
    sb.delete();
    tcnt_m = 0;
    tick();
    check_reset_state("reset");
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int s, target, w;
    rst = 1'b1; valid_tri = 1'b0; sub_sample = 4'b1000;
    screen[0] = 24'd1920; screen[1] = 24'd1080;
    for (int v = 0; v < 3; v++) for (int a = 0; a < 3; a++) tri_in[v][a] = 24'sd0;
    for (int c = 0; c < 3; c++) color_in[c] = 24'd0;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) box_in[i][j] = 24'sd0;
    repeat (3) tick();
    do_reset();
    mon_en = 1'b1;

    // Directed: basic, back-to-back, unaligned, degenerate, inverted, negative, positive limit.
    send(0, 0, 1024, 1024);
    drain();
    sub_sample = 4'b0100;
    send(0, 0, 1024, 1024);
    send(0, 0, 1024, 1024);
    drain();
    sub_sample = 4'b1000;
    send(300, 700, 1500, 1100);
    send(2048, 2048, 2048, 2048);
    send(2048, 0, 1024, 1024);
    send(-1500, -300, -1, 700);
    send(8386560, 0, 8388607, 0);
    drain();

    // Reset on the third sample of a 9-sample box, then a fresh walk.
    sub_sample = 4'b0100;
    target = seen + 3;
    send(0, 0, 1024, 1024);
    w = 0;
    while (seen < target && w < 50) begin tick(); w++; end
    chk("reached_third_sample", seen, target);
    do_reset();
    send(512, 512, 1024, 1024);
    drain();

    // Stats sequence after a clean reset: 4, 9, 1 back to back.
    do_reset();
    send(0, 0, 512, 512);
    send(0, 0, 1024, 1024);
    send(1536, 1536, 1536, 1536);
    drain();

    for (int g = 0; g < 4; g++) begin
      sub_sample = 4'(1 << g);
      s = step_of(sub_sample);
      for (int i = 0; i < 25; i++) begin
        int llx = int'($urandom_range(0, 8000)) - 4000;
        int lly = int'($urandom_range(0, 8000)) - 4000;
        int wx  = int'($urandom_range(0, 4 * s)) - s / 2;
        int wy  = int'($urandom_range(0, 4 * s)) - s / 2;
        send(llx, lly, llx + wx, lly + wy);
        if ($urandom_range(0, 3) == 0) begin
          valid_tri = 1'b0;
          repeat ($urandom_range(1, 3)) tick();
        end
      end
      drain();
    end

    repeat (2) tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
